// File: rtl/mage_pkg.sv
// mage_pkg: shared crossbar widths and load/store stream scheduler types
package mage_pkg;
    localparam int LOG_N_AGE_PER_STREAM = 2;
    localparam int LOG_N_PE_PER_GROUP   = 2;
    localparam int LSS_DUR_W            = 8;

    typedef struct packed {
        logic [LOG_N_AGE_PER_STREAM-1:0] l_sel;
        logic [LOG_N_PE_PER_GROUP-1:0]   s_sel;
        logic [LSS_DUR_W-1:0]            dur;
    } lss_entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} lss_state_e;
endpackage

// File: rtl/lss_sched_table.sv
// lss_sched_table: schedule entry register array, one write port, combinational read
module lss_sched_table
    import mage_pkg::*;
#(
    parameter int N_ENTRIES     = 8,
    parameter int LOG_N_ENTRIES = $clog2(N_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [LOG_N_ENTRIES-1:0] waddr_i,
    input  lss_entry_t               wdata_i,
    input  logic [LOG_N_ENTRIES-1:0] raddr_i,
    output lss_entry_t               rdata_o
);
    lss_entry_t tab_q [N_ENTRIES];

    // table storage, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENTRIES; i++) tab_q[i] <= '0;
        end else if (we_i) begin
            tab_q[waddr_i] <= wdata_i;
        end
    end

    // write-through so an entry written in the start cycle is the one the run loads
    assign rdata_o = (we_i && waddr_i == raddr_i) ? wdata_i : tab_q[raddr_i];
endmodule

// File: rtl/load_store_stream_sched.sv
// load_store_stream_sched: time-multiplexed load/store selector sequencer; LSS_SCHED_PERF_EN adds a stall counter
module load_store_stream_sched
    import mage_pkg::*;
#(
    parameter int N_ENTRIES     = 8,
    parameter int LOG_N_ENTRIES = $clog2(N_ENTRIES),
    parameter int DUR_W         = LSS_DUR_W,
    parameter int ITER_W        = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_we_i,
    input  logic [LOG_N_ENTRIES-1:0]        cfg_addr_i,
    input  logic [LOG_N_AGE_PER_STREAM-1:0] cfg_l_sel_i,
    input  logic [LOG_N_PE_PER_GROUP-1:0]   cfg_s_sel_i,
    input  logic [DUR_W-1:0]                cfg_dur_i,
    input  logic [LOG_N_ENTRIES:0]          cfg_n_entries_i,
    input  logic [ITER_W-1:0]               cfg_n_iter_i,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            stall_i,
    output logic [LOG_N_AGE_PER_STREAM-1:0] l_stream_sel_o,
    output logic [LOG_N_PE_PER_GROUP-1:0]   s_stream_sel_o,
    output logic                            sel_valid_o,
    output logic [LOG_N_ENTRIES-1:0]        entry_idx_o,
    output logic                            busy_o,
    output logic                            done_o
`ifdef LSS_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_stall_cnt_o
`endif
);
    lss_state_e                      state_q, state_d;
    logic [LOG_N_ENTRIES-1:0]        entry_q, entry_d, nxt_entry, raddr;
    logic [ITER_W-1:0]               iter_q, iter_d, n_iter_q, n_iter_d;
    logic [DUR_W-1:0]                dur_q, dur_d, rd_dur;
    logic [LOG_N_ENTRIES:0]          n_ent_q, n_ent_d, n_ent_clamp;
    logic [LOG_N_AGE_PER_STREAM-1:0] l_sel_q, l_sel_d;
    logic [LOG_N_PE_PER_GROUP-1:0]   s_sel_q, s_sel_d;
    logic                            last_entry, last_iter;
    lss_entry_t                      wr_entry, rd_entry;

    assign wr_entry = '{l_sel: cfg_l_sel_i, s_sel: cfg_s_sel_i, dur: LSS_DUR_W'(cfg_dur_i)};

    lss_sched_table #(
        .N_ENTRIES     (N_ENTRIES),
        .LOG_N_ENTRIES (LOG_N_ENTRIES)
    ) u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (cfg_we_i && state_q == IDLE),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_entry),
        .raddr_i (raddr),
        .rdata_o (rd_entry)
    );

    assign n_ent_clamp = (cfg_n_entries_i > (LOG_N_ENTRIES+1)'(N_ENTRIES)) ? (LOG_N_ENTRIES+1)'(N_ENTRIES) : cfg_n_entries_i;
    assign rd_dur      = (rd_entry.dur == '0) ? DUR_W'(1) : DUR_W'(rd_entry.dur);
    assign last_entry  = {1'b0, entry_q} == n_ent_q - (LOG_N_ENTRIES+1)'(1);
    assign last_iter   = iter_q == n_iter_q - ITER_W'(1);
    assign nxt_entry   = last_entry ? '0 : entry_q + LOG_N_ENTRIES'(1);
    assign raddr       = (state_q == RUN) ? nxt_entry : '0;

    // next-state: start sampling, duration countdown, entry/iteration walk, abort
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        iter_d   = iter_q;
        dur_d    = dur_q;
        n_ent_d  = n_ent_q;
        n_iter_d = n_iter_q;
        l_sel_d  = l_sel_q;
        s_sel_d  = s_sel_q;
        if (abort_i) begin
            state_d = IDLE;
            entry_d = '0;
            iter_d  = '0;
            dur_d   = '0;
            l_sel_d = '0;
            s_sel_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    n_ent_d  = n_ent_clamp;
                    n_iter_d = cfg_n_iter_i;
                    if (n_ent_clamp == '0 || cfg_n_iter_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        entry_d = '0;
                        iter_d  = '0;
                        dur_d   = rd_dur;
                        l_sel_d = rd_entry.l_sel;
                        s_sel_d = rd_entry.s_sel;
                    end
                end
                RUN: if (!stall_i) begin
                    if (dur_q > DUR_W'(1)) begin
                        dur_d = dur_q - DUR_W'(1);
                    end else if (last_entry && last_iter) begin
                        state_d = DONE;
                        entry_d = '0;
                        dur_d   = '0;
                        l_sel_d = '0;
                        s_sel_d = '0;
                    end else begin
                        entry_d = nxt_entry;
                        iter_d  = last_entry ? iter_q + ITER_W'(1) : iter_q;
                        dur_d   = rd_dur;
                        l_sel_d = rd_entry.l_sel;
                        s_sel_d = rd_entry.s_sel;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            iter_q   <= '0;
            dur_q    <= '0;
            n_ent_q  <= '0;
            n_iter_q <= '0;
            l_sel_q  <= '0;
            s_sel_q  <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            iter_q   <= iter_d;
            dur_q    <= dur_d;
            n_ent_q  <= n_ent_d;
            n_iter_q <= n_iter_d;
            l_sel_q  <= l_sel_d;
            s_sel_q  <= s_sel_d;
        end
    end

    assign l_stream_sel_o = l_sel_q;
    assign s_stream_sel_o = s_sel_q;
    assign sel_valid_o    = state_q == RUN;
    assign entry_idx_o    = entry_q;
    assign busy_o         = state_q != IDLE;
    assign done_o         = state_q == DONE;

`ifdef LSS_SCHED_PERF_EN
    logic [31:0] perf_q;

    // stalled RUN cycles, restarted by each accepted start, saturating
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (state_q == IDLE && start_i && !abort_i) begin
            perf_q <= '0;
        end else if (state_q == RUN && stall_i && !(&perf_q)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_load_store_stream_sched.sv
// tb_load_store_stream_sched: randomized scenario bench against a slot-list schedule model
module tb_load_store_stream_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_l_sel = '0;
    logic [1:0] cfg_s_sel = '0;
    logic [7:0] cfg_dur = '0;
    logic [3:0] cfg_n_entries = '0;
    logic [7:0] cfg_n_iter = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] l_sel, s_sel;
    logic       sel_valid, busy, done;
    logic [2:0] entry_idx;
`ifdef LSS_SCHED_PERF_EN
    logic [31:0] perf;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] ml [8];
    logic [1:0] ms [8];
    int         md [8];

    load_store_stream_sched dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_we_i        (cfg_we),
        .cfg_addr_i      (cfg_addr),
        .cfg_l_sel_i     (cfg_l_sel),
        .cfg_s_sel_i     (cfg_s_sel),
        .cfg_dur_i       (cfg_dur),
        .cfg_n_entries_i (cfg_n_entries),
        .cfg_n_iter_i    (cfg_n_iter),
        .start_i         (start),
        .abort_i         (abort),
        .stall_i         (stall),
        .l_stream_sel_o  (l_sel),
        .s_stream_sel_o  (s_sel),
        .sel_valid_o     (sel_valid),
        .entry_idx_o     (entry_idx),
        .busy_o          (busy),
        .done_o          (done)
`ifdef LSS_SCHED_PERF_EN
        ,
        .perf_stall_cnt_o(perf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int l, input int s, input int d);
        cfg_we = 1'b1;
        cfg_addr = 3'(a);
        cfg_l_sel = 2'(l);
        cfg_s_sel = 2'(s);
        cfg_dur = 8'(d);
        tick();
        cfg_we = 1'b0;
        ml[a] = 2'(l);
        ms[a] = 2'(s);
        md[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            ml[i] = '0;
            ms[i] = '0;
            md[i] = 0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (l_sel !== 0 || s_sel !== 0 || sel_valid !== 0 || entry_idx !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset: got l=%0d s=%0d v=%0d e=%0d busy=%0d done=%0d exp all 0", l_sel, s_sel, sel_valid, entry_idx, busy, done);
        end
    endtask

    // expected outputs come from an expanded list of one slot per unstalled hold cycle
    task automatic test_schedule(input string name, input int ne_cfg, input int ni, input int pct, input logic [31:0] mask);
        int slots[$];
        int ne, pos, cyc, stalls, e;
        logic st;
        ne = ne_cfg > 8 ? 8 : ne_cfg;
        for (int it = 0; it < ni; it++)
            for (int k = 0; k < ne; k++)
                for (int r = 0; r < (md[k] == 0 ? 1 : md[k]); r++) slots.push_back(k);
        cfg_n_entries = 4'(ne_cfg);
        cfg_n_iter = 8'(ni);
        start = 1'b1;
        tick();
        start = 1'b0;
        pos = 0;
        cyc = 0;
        stalls = 0;
        while (pos < slots.size()) begin
            e = slots[pos];
            checks++;
            if (sel_valid !== 1 || busy !== 1 || done !== 0 || entry_idx !== 3'(e) || l_sel !== ml[e] || s_sel !== ms[e]) begin
                errors++;
                $display("FAIL %s cyc%0d: got v=%0d e=%0d l=%0d s=%0d done=%0d exp v=1 e=%0d l=%0d s=%0d done=0",
                         name, cyc, sel_valid, entry_idx, l_sel, s_sel, done, e, ml[e], ms[e]);
            end
            st = (cyc < 32) ? (mask[cyc] || ($urandom_range(99) < pct)) : ($urandom_range(99) < pct);
            stall = st;
            if (st) stalls++;
            tick();
            if (!st) pos++;
            cyc++;
            if (cyc > 4000) begin
                errors++;
                $display("FAIL %s: cycle budget exceeded", name);
                break;
            end
        end
        stall = 1'b0;
        checks++;
        if (done !== 1 || busy !== 1 || sel_valid !== 0) begin
            errors++;
            $display("FAIL %s done: got done=%0d busy=%0d v=%0d exp 1 1 0", name, done, busy, sel_valid);
        end
`ifdef LSS_SCHED_PERF_EN
        checks++;
        if (perf !== 32'(stalls)) begin
            errors++;
            $display("FAIL %s perf: got %0d exp %0d", name, perf, stalls);
        end
`endif
        tick();
        checks++;
        if (done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL %s idle: got done=%0d busy=%0d exp 0 0", name, done, busy);
        end
    endtask

    task automatic test_basic();
        wr(0, 1, 2, 3);
        wr(1, 0, 1, 1);
        test_schedule("basic", 2, 2, 0, 32'h0);
    endtask

    task automatic test_stall();
        test_schedule("stall", 2, 2, 0, 32'b0110);
    endtask

    task automatic test_zero();
        test_schedule("zero_iter", 2, 0, 0, 32'h0);
        test_schedule("zero_entries", 0, 3, 0, 32'h0);
    endtask

    task automatic test_abort();
        int n = 0;
        cfg_n_entries = 4'd2;
        cfg_n_iter = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (entry_idx !== 3'd1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (entry_idx !== 3'd1) begin
            errors++;
            $display("FAIL abort_reach: got e=%0d exp 1", entry_idx);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 0 || sel_valid !== 0 || l_sel !== 0 || s_sel !== 0 || entry_idx !== 0 || done !== 0) begin
            errors++;
            $display("FAIL abort: got busy=%0d v=%0d l=%0d s=%0d e=%0d done=%0d exp all 0", busy, sel_valid, l_sel, s_sel, entry_idx, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL abort_quiet: got done=%0d busy=%0d exp 0 0", done, busy);
            end
        end
        test_schedule("abort_replay", 2, 1, 0, 32'h0);
    endtask

    task automatic test_cfg_write();
        int n = 0;
        wr(0, 1, 2, 4);
        cfg_n_entries = 4'd1;
        cfg_n_iter = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_l_sel = 2'd3;
        tick();
        cfg_we = 1'b0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        test_schedule("run_write_ignored", 1, 1, 0, 32'h0);
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_l_sel = 2'd3;
        cfg_s_sel = 2'd1;
        cfg_dur = 8'd2;
        ml[0] = 2'd3;
        ms[0] = 2'd1;
        md[0] = 2;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        checks++;
        if (sel_valid !== 1 || l_sel !== 2'd3 || s_sel !== 2'd1) begin
            errors++;
            $display("FAIL write_with_start: got v=%0d l=%0d s=%0d exp 1 3 1", sel_valid, l_sel, s_sel);
        end
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        test_schedule("write_with_start_replay", 1, 2, 0, 32'h0);
    endtask

    task automatic test_clamp_dur0();
        for (int i = 0; i < 8; i++) wr(i, $urandom_range(3), $urandom_range(3), (i % 3 == 0) ? 0 : $urandom_range(3));
        test_schedule("clamp_dur0", 15, 2, 0, 32'h0);
    endtask

    task automatic test_reset_mid_run();
        cfg_n_entries = 4'd4;
        cfg_n_iter = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_reset();
        clear_model();
        test_schedule("post_reset_table_cleared", 3, 1, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 3; k++) wr($urandom_range(7), $urandom_range(3), $urandom_range(3), $urandom_range(4));
            test_schedule("random", $urandom_range(10), $urandom_range(3), 30, 32'h0);
        end
    endtask

    initial begin
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
        test_cfg_write();
        test_clamp_dur0();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
